// File: rtl/calc_reduce_alu_pkg.sv
// Shared types for the calc_reduce_alu reduction stage.
// Op and state encodings plus the signed-add overflow helper.
package calc_reduce_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAX = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CALC  = 2'd2,
        S_PUSH  = 2'd3
    } state_e;

    localparam int DEF_WIDTH        = 48;
    localparam int DEF_OPERANDS     = 2;
    localparam int DEF_READ_LATENCY = 1;

    // Signed overflow of s = a + b, from the three sign bits.
    function automatic logic add_ovf(
        input logic sa,
        input logic sb,
        input logic ss
    );
        return (sa == sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/calc_reduce_alu_if.sv
// FIFO-side bundle of calc_reduce_alu: input FIFO read, output FIFO write.
// The master side owns the FIFOs, the slave side is the reduction stage.
interface calc_reduce_alu_if #(
    parameter int W = 48
);
    logic [1:0]   op;
    logic [W-1:0] a;
    logic         empty;
    logic         full;
    logic         rden;
    logic [W-1:0] c;
    logic         ovf;
    logic         wren;
    logic         busy;

    modport master (
        output op, a, empty, full,
        input  rden, c, ovf, wren, busy
    );

    modport slave (
        input  op, a, empty, full,
        output rden, c, ovf, wren, busy
    );
endinterface

// File: rtl/calc_reduce_alu_fold_unit.sv
// One fold step f(acc, a, op) of the reduction, purely combinational.
// Also reports whether this single step overflowed the result width.
module calc_fold_unit
    import calc_reduce_alu_pkg::*;
#(
    parameter int W = DEF_WIDTH
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  op_e          op,
    output logic [W-1:0] res,
    output logic         step_ovf
);
    logic [W-1:0]          sum;
    logic [W-1:0]          diff;
    logic signed [2*W-1:0] acc_x;
    logic signed [2*W-1:0] a_x;
    logic signed [2*W-1:0] prod;
    logic                  mul_ovf;

    assign sum   = acc + a;
    assign diff  = acc - a;
    assign acc_x = {{W{acc[W-1]}}, acc};
    assign a_x   = {{W{a[W-1]}}, a};
    assign prod  = acc_x * a_x;

    // Kept half is exact only if the dropped half is its sign extension.
    assign mul_ovf = prod[2*W-1:W] != {W{prod[W-1]}};

    always_comb begin
        res      = sum;
        step_ovf = 1'b0;
        unique case (op)
            OP_ADD: begin
                res      = sum;
                step_ovf = add_ovf(acc[W-1], a[W-1], sum[W-1]);
            end
            OP_SUB: begin
                res      = diff;
                step_ovf = add_ovf(acc[W-1], ~a[W-1], diff[W-1]);
            end
            OP_MUL: begin
                res      = prod[W-1:0];
                step_ovf = mul_ovf;
            end
            OP_MAX: begin
                res      = ($signed(acc) > $signed(a)) ? acc : a;
                step_ovf = 1'b0;
            end
            default: begin
                res      = sum;
                step_ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_reduce_alu.sv
// Reduction stage: pops OPERANDS words, folds them with a latched op,
// and pushes one result plus a sticky overflow flag to the output FIFO.
module calc_reduce_alu
    import calc_reduce_alu_pkg::*;
#(
    parameter int RAH_PACKET_WIDTH = DEF_WIDTH,
    parameter int OPERANDS         = DEF_OPERANDS,
    parameter int READ_LATENCY     = DEF_READ_LATENCY
) (
    input logic               clk,
    input logic               rst,
    calc_reduce_alu_if.slave  bus
);
    localparam int W  = RAH_PACKET_WIDTH;
    localparam int CW = $clog2(OPERANDS + 1);

    localparam logic [CW-1:0] NOPS = CW'(OPERANDS);
    localparam logic [CW-1:0] LAST = CW'(OPERANDS - 1);

    state_e state;
    state_e state_nxt;
    op_e    op_q;

    logic [CW-1:0]           issued;
    logic [CW-1:0]           captured;
    logic [READ_LATENCY-1:0] vpipe;
    logic [READ_LATENCY:0]   pipe_d;

    logic [W-1:0] acc;
    logic [W-1:0] c_q;
    logic [W-1:0] fold_res;
    logic         fold_ovf;
    logic         sticky;
    logic         ovf_q;

    logic rden;
    logic wren;
    logic busy;
    logic capture;
    logic last_cap;

    // Valid pipe tracks which cycle a requested word appears on a.
    assign pipe_d   = {vpipe, rden};
    assign capture  = vpipe[READ_LATENCY-1];
    assign last_cap = capture && (captured == LAST);

    calc_fold_unit #(
        .W (W)
    ) u_fold (
        .acc      (acc),
        .a        (bus.a),
        .op       (op_q),
        .res      (fold_res),
        .step_ovf (fold_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (!bus.empty) state_nxt = S_FETCH;
            S_FETCH: if (last_cap)   state_nxt = S_CALC;
            S_CALC:                  state_nxt = S_PUSH;
            S_PUSH:  if (!bus.full)  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rden = 1'b0;
        wren = 1'b0;
        busy = 1'b1;
        unique case (state)
            S_IDLE:  busy = 1'b0;
            S_FETCH: rden = (issued < NOPS) && !bus.empty;
            S_CALC:  wren = 1'b0;
            S_PUSH:  wren = !bus.full;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            issued   <= '0;
            captured <= '0;
            vpipe    <= '0;
            acc      <= '0;
            sticky   <= 1'b0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            vpipe <= pipe_d[READ_LATENCY-1:0];
            if (state == S_IDLE) begin
                issued   <= '0;
                captured <= '0;
                if (!bus.empty) begin
                    op_q <= op_e'(bus.op);
                end
            end
            if (rden) begin
                issued <= issued + 1'b1;
            end
            if (capture) begin
                captured <= captured + 1'b1;
                if (captured == '0) begin
                    acc    <= bus.a;
                    sticky <= 1'b0;
                end else begin
                    acc    <= fold_res;
                    sticky <= sticky | fold_ovf;
                end
            end
            if (state == S_CALC) begin
                c_q   <= acc;
                ovf_q <= sticky;
            end
        end
    end

    assign bus.rden = rden;
    assign bus.wren = wren;
    assign bus.busy = busy;
    assign bus.c    = c_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_calc_reduce_alu.sv
// Bench for calc_reduce_alu: two configurations fed from modelled FIFOs,
// results checked through a per-instance expected-value queue.
module tb_calc_reduce_alu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    calc_reduce_alu_if #(.W(48)) b0 ();
    calc_reduce_alu_if #(.W(48)) b1 ();

    calc_reduce_alu #(
        .RAH_PACKET_WIDTH (48),
        .OPERANDS         (2),
        .READ_LATENCY     (1)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    calc_reduce_alu #(
        .RAH_PACKET_WIDTH (48),
        .OPERANDS         (4),
        .READ_LATENCY     (2)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    logic [47:0] mem0 [0:1023];
    logic [47:0] mem1 [0:1023];
    logic [47:0] d1;
    int wr0 = 0;
    int rd0 = 0;
    int wr1 = 0;
    int rd1 = 0;
    logic force1 = 1'b0;

    assign b0.empty = (rd0 == wr0);
    assign b1.empty = (rd1 == wr1) || force1;

    // Input FIFO models: 1-cycle and 2-cycle read latency.
    always @(posedge clk) begin
        if (b0.rden) begin
            b0.a <= mem0[rd0[9:0]];
            rd0  <= rd0 + 1;
        end
    end

    always @(posedge clk) begin
        d1   <= mem1[rd1[9:0]];
        b1.a <= d1;
        if (b1.rden) rd1 <= rd1 + 1;
    end

    logic [48:0] exp0 [$];
    logic [48:0] exp1 [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int viol = 0;
    int first0 = -1;
    int first1 = -1;
    int lat0 = 0;
    int lat1 = 0;
    int wrn0 = 0;
    int wrn1 = 0;

    function automatic logic signed [95:0] sx(input logic [47:0] v);
        return {{48{v[47]}}, v};
    endfunction

    // Exact-arithmetic reference: overflow means the true value left the range.
    function automatic logic [48:0] ref_fold(
        input logic [1:0]  op,
        input logic [47:0] w [4],
        input int          n
    );
        logic signed [95:0] acc;
        logic signed [95:0] b;
        logic signed [95:0] ex;
        logic signed [95:0] hi;
        logic signed [95:0] lo;
        logic ov;
        hi  = sx(48'h7FFF_FFFF_FFFF);
        lo  = sx(48'h8000_0000_0000);
        acc = sx(w[0]);
        ov  = 1'b0;
        for (int i = 1; i < n; i++) begin
            b = sx(w[i]);
            case (op)
                2'd0:    ex = acc + b;
                2'd1:    ex = acc - b;
                2'd2:    ex = acc * b;
                default: ex = (acc > b) ? acc : b;
            endcase
            if (ex > hi || ex < lo) ov = 1'b1;
            acc = sx(ex[47:0]);
        end
        return {ov, acc[47:0]};
    endfunction

    function automatic logic [47:0] rnd_word();
        logic [63:0] r;
        int s;
        r = {$urandom, $urandom};
        s = int'($urandom_range(0, 2000)) - 1000;
        case ($urandom_range(0, 3))
            0:       return 48'(s);
            1:       return 48'h7FFF_FFFF_FFFF - 48'($urandom_range(0, 3));
            2:       return r[47:0];
            default: return 48'(s) << 20;
        endcase
    endfunction

    function automatic logic [48:0] mk(input logic ov, input logic signed [47:0] v);
        return {ov, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] req);
        tests++;
        assert (got === req) else begin
            fails++;
            $error("FAIL %s got=%0h required=%0h", tag, got, req);
        end
    endtask

    task automatic observe();
        logic [48:0] e;
        if (b0.rden && b0.empty) viol++;
        if (b1.rden && b1.empty) viol++;
        if (b0.rden && first0 < 0) first0 = cyc;
        if (b1.rden && first1 < 0) first1 = cyc;
        if (b0.wren) begin
            lat0 = cyc - first0;
            first0 = -1;
            wrn0++;
            tests++;
            assert (exp0.size() > 0) else begin
                fails++;
                $error("FAIL sb0_extra got c=%0d required=no push", $signed(b0.c));
            end
            if (exp0.size() > 0) begin
                e = exp0.pop_front();
                tests++;
                assert ({b0.ovf, b0.c} === e) else begin
                    fails++;
                    $error("FAIL sb0 got c=%0d ovf=%0b required c=%0d ovf=%0b",
                           $signed(b0.c), b0.ovf, $signed(e[47:0]), e[48]);
                end
            end
        end
        if (b1.wren) begin
            lat1 = cyc - first1;
            first1 = -1;
            wrn1++;
            tests++;
            assert (exp1.size() > 0) else begin
                fails++;
                $error("FAIL sb1_extra got c=%0d required=no push", $signed(b1.c));
            end
            if (exp1.size() > 0) begin
                e = exp1.pop_front();
                tests++;
                assert ({b1.ovf, b1.c} === e) else begin
                    fails++;
                    $error("FAIL sb1 got c=%0d ovf=%0b required c=%0d ovf=%0b",
                           $signed(b1.c), b1.ovf, $signed(e[47:0]), e[48]);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic push0(input logic [47:0] w);
        mem0[wr0[9:0]] = w;
        wr0++;
    endtask

    task automatic push1(input logic [47:0] w);
        mem1[wr1[9:0]] = w;
        wr1++;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0 && !b0.busy && !b1.busy
                && b0.empty && b1.empty) done = 1'b1;
            else tick();
        end
        tests++;
        assert (done) else begin
            fails++;
            $error("FAIL %s_timeout got=busy required=idle", tag);
        end
    endtask

    initial begin
        logic [47:0] w [4];
        logic [48:0] e;
        int base;
        int nw;
        logic seen;

        b0.op = 2'd0;
        b1.op = 2'd0;
        b0.full = 1'b0;
        b1.full = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_c", 64'(b0.c), 64'd0);
        chk("rst_ovf", 64'(b0.ovf), 64'd0);
        chk("rst_wren", 64'({b0.wren, b1.wren}), 64'd0);
        chk("rst_busy", 64'({b0.busy, b1.busy}), 64'd0);
        chk("rst_rden", 64'({b0.rden, b1.rden}), 64'd0);
        rst = 1'b0;
        tick();

        // T1: SUB {10,3}
        base = rd0;
        b0.op = 2'd1;
        push0(48'd10);
        push0(48'd3);
        exp0.push_back(mk(1'b0, 48'sd7));
        wait_idle("t1");
        chk("t1_pops", 64'(rd0 - base), 64'd2);
        chk("t1_latency", 64'(lat0), 64'd4);

        // T2: ADD wrap, MUL high-half loss, MAX of negatives
        b0.op = 2'd0;
        push0(48'h7FFF_FFFF_FFFF);
        push0(48'd1);
        exp0.push_back({1'b1, 48'h8000_0000_0000});
        wait_idle("t2_add");
        b0.op = 2'd2;
        push0(48'h100_0000);
        push0(48'h100_0000);
        exp0.push_back({1'b1, 48'h0});
        wait_idle("t2_mul");
        b0.op = 2'd3;
        push0(-48'sd5);
        push0(-48'sd9);
        exp0.push_back(mk(1'b0, -48'sd5));
        wait_idle("t2_max");

        // Four-operand instance, no stalls
        b1.op = 2'd0;
        push1(48'd100);
        push1(-48'sd30);
        push1(48'd7);
        push1(-48'sd1);
        exp1.push_back(mk(1'b0, 48'sd76));
        wait_idle("t3_nostall");
        chk("t3_latency", 64'(lat1), 64'd7);

        // T3: empty forced high for 3 cycles after the 2nd pop
        base = rd1;
        viol = 0;
        b1.op = 2'd0;
        push1(48'd1);
        push1(48'd2);
        push1(48'd3);
        push1(48'd4);
        exp1.push_back(mk(1'b0, 48'sd10));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (rd1 - base >= 2) seen = 1'b1;
            else tick();
        end
        chk("t3_reach_2nd_pop", 64'(seen), 64'd1);
        force1 = 1'b1;
        tick();
        tick();
        tick();
        force1 = 1'b0;
        wait_idle("t3");
        chk("t3_pops", 64'(rd1 - base), 64'd4);
        chk("t3_rden_while_empty", 64'(viol), 64'd0);

        // T4: output FIFO full when PUSH is reached
        b0.full = 1'b1;
        b0.op = 2'd0;
        nw = wrn0;
        push0(48'd20);
        push0(48'd5);
        exp0.push_back(mk(1'b0, 48'sd25));
        for (int i = 0; i < 8; i++) tick();
        chk("t4_c_held", 64'(b0.c), 64'd25);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_no_wren", 64'(wrn0 - nw), 64'd0);
        chk("t4_c_stable", 64'({b0.ovf, b0.c}), 64'd25);
        chk("t4_busy", 64'(b0.busy), 64'd1);
        b0.full = 1'b0;
        #1;
        observe();
        chk("t4_wren_after_full", 64'(b0.wren), 64'd1);
        wait_idle("t4");
        chk("t4_one_wren", 64'(wrn0 - nw), 64'd1);

        // T5: reset mid-FETCH after one of two pops
        b0.op = 2'd1;
        base = rd0;
        nw = wrn0;
        push0(48'd50);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rd0 - base >= 1) seen = 1'b1;
            else tick();
        end
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_outputs", 64'({b0.rden, b0.wren, b0.busy, b0.ovf}), 64'd0);
        chk("t5_rst_c", 64'(b0.c), 64'd0);
        tick();
        rst = 1'b0;
        first0 = -1;
        tick();
        chk("t5_pops", 64'(rd0 - base), 64'd1);
        push0(48'd8);
        push0(48'd5);
        exp0.push_back(mk(1'b0, 48'sd3));
        wait_idle("t5");
        chk("t5_wrens", 64'(wrn0 - nw), 64'd1);

        // T6: op change mid-FETCH is ignored
        b0.op = 2'd0;
        push0(48'd5);
        push0(48'd6);
        exp0.push_back(mk(1'b0, 48'sd11));
        tick();
        b0.op = 2'd1;
        wait_idle("t6");

        // Random streams against the reference fold
        for (int t = 0; t < 16; t++) begin
            b0.op = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) w[i] = rnd_word();
            push0(w[0]);
            push0(w[1]);
            e = ref_fold(b0.op, w, 2);
            exp0.push_back(e);
            wait_idle("rnd0");
        end
        for (int t = 0; t < 10; t++) begin
            b1.op = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                w[i] = rnd_word();
                push1(w[i]);
            end
            e = ref_fold(b1.op, w, 4);
            exp1.push_back(e);
            wait_idle("rnd1");
        end
        chk("final_rden_while_empty", 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
